// File: rtl/mlp_pkg.sv
// Shared MLP definitions: parameter-loader FSM states and FP32 classification helpers.
package mlp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } loader_state_t;

  localparam logic [7:0] FP32_EXP_ONES = 8'hFF;

  // NaN: all-ones exponent with a non-zero mantissa; +/-Inf has a zero mantissa.
  function automatic logic fp32_is_nan(input logic [31:0] word);
    return (word[30:23] == FP32_EXP_ONES) && (word[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/layer_param_loader.sv
// Streams N_WEIGHTS weights then N_NEURONS biases into memories; write strobe 1 cycle after accept.
// Backpressure: s_ready is high only while loading, words offered in IDLE/DONE are left unconsumed.
module layer_param_loader
  import mlp_pkg::*;
#(
  parameter int N_NEURONS = 128,
  parameter int N_INPUTS  = 784,
  parameter int N_WEIGHTS = 100352
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         start,
  input  logic [31:0]                  s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         w_we,
  output logic [$clog2(N_WEIGHTS)-1:0] w_addr,
  output logic [31:0]                  w_data,
  output logic                         b_we,
  output logic [$clog2(N_NEURONS)-1:0] b_addr,
  output logic [31:0]                  b_data,
  output logic                         busy,
  output logic                         done,
  output logic                         nan_seen
);

  localparam int WAW = $clog2(N_WEIGHTS);
  localparam int BAW = $clog2(N_NEURONS);
  localparam logic [WAW-1:0] W_LAST = WAW'(N_WEIGHTS - 1);
  localparam logic [BAW-1:0] B_LAST = BAW'(N_NEURONS - 1);
  localparam logic [WAW-1:0] W_ONE  = WAW'(1);
  localparam logic [BAW-1:0] B_ONE  = BAW'(1);

  if (N_WEIGHTS != N_NEURONS * N_INPUTS) begin : g_bad_weight_count
    $fatal(1, "layer_param_loader: N_WEIGHTS must equal N_NEURONS*N_INPUTS");
  end

  loader_state_t  state_q, state_d;
  logic [WAW-1:0] w_cnt_q, w_cnt_d;
  logic [BAW-1:0] b_cnt_q, b_cnt_d;
  logic           s_ready_q, s_ready_d;
  logic           w_we_q, w_we_d;
  logic [WAW-1:0] w_addr_q, w_addr_d;
  logic [31:0]    w_data_q, w_data_d;
  logic           b_we_q, b_we_d;
  logic [BAW-1:0] b_addr_q, b_addr_d;
  logic [31:0]    b_data_q, b_data_d;
  logic           nan_q, nan_d;
  logic           accept;

  assign accept = s_valid && s_ready_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      w_cnt_q   <= '0;
      b_cnt_q   <= '0;
      s_ready_q <= 1'b0;
      w_we_q    <= 1'b0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      b_we_q    <= 1'b0;
      b_addr_q  <= '0;
      b_data_q  <= '0;
      nan_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_cnt_q   <= w_cnt_d;
      b_cnt_q   <= b_cnt_d;
      s_ready_q <= s_ready_d;
      w_we_q    <= w_we_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      b_we_q    <= b_we_d;
      b_addr_q  <= b_addr_d;
      b_data_q  <= b_data_d;
      nan_q     <= nan_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    w_cnt_d  = w_cnt_q;
    b_cnt_d  = b_cnt_q;
    w_we_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    b_we_d   = 1'b0;
    b_addr_d = b_addr_q;
    b_data_d = b_data_q;
    nan_d    = nan_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD_W;
          w_cnt_d = '0;
          b_cnt_d = '0;
          nan_d   = 1'b0;
        end
      end
      ST_LOAD_W: begin
        if (accept) begin
          w_we_d   = 1'b1;
          w_addr_d = w_cnt_q;
          w_data_d = s_data;
          if (fp32_is_nan(s_data)) nan_d = 1'b1;
          // Terminal index hands over to the bias phase instead of wrapping.
          if (w_cnt_q == W_LAST) begin
            state_d = ST_LOAD_B;
            w_cnt_d = '0;
          end else begin
            w_cnt_d = w_cnt_q + W_ONE;
          end
        end
      end
      ST_LOAD_B: begin
        if (accept) begin
          b_we_d   = 1'b1;
          b_addr_d = b_cnt_q;
          b_data_d = s_data;
          if (fp32_is_nan(s_data)) nan_d = 1'b1;
          if (b_cnt_q == B_LAST) begin
            state_d = ST_DONE;
            b_cnt_d = '0;
          end else begin
            b_cnt_d = b_cnt_q + B_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    s_ready_d = (state_d == ST_LOAD_W) || (state_d == ST_LOAD_B);
  end

  assign s_ready  = s_ready_q;
  assign w_we     = w_we_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign b_we     = b_we_q;
  assign b_addr   = b_addr_q;
  assign b_data   = b_data_q;
  assign busy     = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_B);
  assign done     = (state_q == ST_DONE);
  assign nan_seen = nan_q;

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed bench for layer_param_loader with a 2-neuron x 3-input layer.
module tb_layer_param_loader;

  localparam int NN = 2;
  localparam int NI = 3;
  localparam int NW = 6;

  logic        clk = 1'b0;
  logic        reset, start, s_valid;
  logic [31:0] s_data;
  logic        s_ready, w_we, b_we, busy, done, nan_seen;
  logic [2:0]  w_addr;
  logic [0:0]  b_addr;
  logic [31:0] w_data, b_data;

  layer_param_loader #(.N_NEURONS(NN), .N_INPUTS(NI), .N_WEIGHTS(NW)) dut (
    .CLK(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .busy(busy), .done(done), .nan_seen(nan_seen)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] word;
    logic        exp_w;
    logic [2:0]  waddr;
    logic        exp_b;
    logic        baddr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then settle just past the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic st);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    start   = st;
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit gap, input int ovr_idx, input logic [31:0] ovr_word,
                          input bit start_in_b);
    logic [31:0] wd;
    for (int i = 0; i < 8; i++) begin
      wd = (i == ovr_idx) ? ovr_word : vecs[i].word;
      step(1'b1, wd, start_in_b && (i == 6));
      chk("w_we", w_we, vecs[i].exp_w);
      chk("b_we", b_we, vecs[i].exp_b);
      if (vecs[i].exp_w) begin
        chk("w_addr", w_addr, vecs[i].waddr);
        chk("w_data", w_data, wd);
      end else begin
        chk("b_addr", b_addr, vecs[i].baddr);
        chk("b_data", b_data, wd);
      end
      if (i < 7) begin
        chk("busy_loading", busy, 1);
      end else begin
        chk("done_after_last", done, 1);
        chk("s_ready_after_last", s_ready, 0);
        chk("busy_after_last", busy, 0);
      end
      if (gap && i < 7) begin
        step(1'b0, 32'hDEADBEEF, 1'b0);
        chk("gap_w_we", w_we, 0);
        chk("gap_b_we", b_we, 0);
        chk("gap_busy", busy, 1);
      end
    end
    step(1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    vecs[0] = '{32'h3F800000, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[1] = '{32'h40000000, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[2] = '{32'h40400000, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[3] = '{32'h40800000, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[4] = '{32'h40A00000, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{32'h40C00000, 1'b1, 3'd5, 1'b0, 1'b0};
    vecs[6] = '{32'h40E00000, 1'b0, 3'd0, 1'b1, 1'b0};
    vecs[7] = '{32'h41000000, 1'b0, 3'd0, 1'b1, 1'b1};

    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_w_we", w_we, 0);
    chk("rst_b_we", b_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nan", nan_seen, 0);
    chk("rst_w_addr", w_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_b_data", b_data, 0);
    reset = 1'b0;

    // Valid words offered while idle are not consumed.
    repeat (3) begin
      step(1'b1, 32'h3F800000, 1'b0);
      chk("idle_s_ready", s_ready, 0);
      chk("idle_w_we", w_we, 0);
      chk("idle_b_we", b_we, 0);
    end

    step(1'b0, 32'h0, 1'b1);
    chk("start_s_ready", s_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);

    run_load(1'b0, -1, 32'h0, 1'b0);
    chk("b2b_nan", nan_seen, 0);

    repeat (3) begin
      step(1'b1, 32'h40000000, 1'b0);
      chk("done_s_ready", s_ready, 0);
      chk("done_w_we", w_we, 0);
      chk("done_b_we", b_we, 0);
      chk("done_held", done, 1);
    end

    // Gapped stream with +Inf at word 2: identical writes, nan_seen stays clear.
    step(1'b0, 32'h0, 1'b1);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    run_load(1'b1, 2, 32'h7F800000, 1'b0);
    chk("inf_nan", nan_seen, 0);

    // Quiet NaN at word 3, plus a start pulse during the bias phase.
    step(1'b0, 32'h0, 1'b1);
    run_load(1'b0, 3, 32'h7FC00000, 1'b1);
    chk("nan_set", nan_seen, 1);
    step(1'b0, 32'h0, 1'b0);
    chk("nan_sticky_done", nan_seen, 1);
    chk("still_done", done, 1);

    step(1'b0, 32'h0, 1'b1);
    chk("start_clears_nan", nan_seen, 0);
    chk("restart2_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vecs[i].word, 1'b0);
      chk("pre_rst_w_we", w_we, 1);
      chk("pre_rst_w_addr", w_addr, vecs[i].waddr);
    end

    // Reset mid-load: pending word must not be written, and a new start is required.
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b1; s_data = 32'h40A00000;
    @(posedge clk);
    #1;
    chk("midrst_w_we", w_we, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    step(1'b1, 32'h40A00000, 1'b0);
    chk("post_rst_w_we", w_we, 0);
    chk("post_rst_s_ready", s_ready, 0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h40E00000, 1'b0);
    chk("reload_w_we", w_we, 1);
    chk("reload_w_addr", w_addr, 0);
    chk("reload_w_data", w_data, 32'h40E00000);
    step(1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_param_loader.md
LAYER_PARAM_LOADER -- requirements
Module: layer_param_loader

Interface
REQ-001 SHALL have parameter N_NEURONS, default 128, neurons in the target dense layer.
REQ-002 SHALL have parameter N_INPUTS, default 784, inputs per neuron.
REQ-003 SHALL have parameter N_WEIGHTS, default 100352, total weight words; SHALL equal N_NEURONS*N_INPUTS, with an elaboration-time fatal error otherwise.
REQ-004 SHALL have port CLK input 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset input 1: synchronous, active-high reset.
REQ-006 SHALL have port start input 1: one-cycle request to begin a load.
REQ-007 SHALL have port s_data input 32: FP32 IEEE 754 parameter word stream.
REQ-008 SHALL have port s_valid input 1: s_data valid.
REQ-009 SHALL have port s_ready output 1: loader accepts a word this cycle.
REQ-010 SHALL have port w_we output 1: weight memory write strobe.
REQ-011 SHALL have port w_addr output $clog2(N_WEIGHTS): weight write index.
REQ-012 SHALL have port w_data output 32: weight write word.
REQ-013 SHALL have port b_we output 1: bias memory write strobe.
REQ-014 SHALL have port b_addr output $clog2(N_NEURONS): bias write index.
REQ-015 SHALL have port b_data output 32: bias write word.
REQ-016 SHALL have port busy output 1: high while in LOAD_W or LOAD_B.
REQ-017 SHALL have port done output 1: high while in DONE.
REQ-018 SHALL have port nan_seen output 1: sticky flag, a NaN word was loaded.

Function
REQ-019 SHALL implement the FSM IDLE -> LOAD_W -> LOAD_B -> DONE, with DONE -> LOAD_W on start.
REQ-020 SHALL go IDLE->LOAD_W on start; SHALL ignore start while busy.
REQ-021 SHALL drive s_ready=1 only in LOAD_W and LOAD_B, as a registered state decode.
REQ-022 SHALL, on each accept (s_valid&&s_ready) in LOAD_W, assert w_we for exactly one cycle on the next cycle, with w_addr=word index and w_data=accepted word (latency 1).
REQ-023 SHALL use neuron-major weight order: index = neuron*N_INPUTS + input; word k goes to w_addr k.
REQ-024 SHALL go to LOAD_B on the accept of weight index N_WEIGHTS-1, with no idle cycle.
REQ-025 SHALL, in LOAD_B, write accepted words to b_addr 0..N_NEURONS-1 with the same 1-cycle latency via b_we.
REQ-026 SHALL go to DONE on the accept of bias N_NEURONS-1; the final b_we pulse occurs in the first DONE cycle.
REQ-027 SHALL never assert w_we and b_we in the same cycle.
REQ-028 SHALL ignore s_valid while s_ready=0 (IDLE/DONE); extra words are not consumed.
REQ-029 SHALL honour gaps in s_valid: the index advances only on accept; there is no timeout.
REQ-030 SHALL set nan_seen when an accepted word has exponent 8'hFF and mantissa !=0; +/-Inf does not set it.
REQ-031 SHALL clear nan_seen on start from IDLE or DONE.
REQ-032 SHALL use counters sized $clog2(N_WEIGHTS) and $clog2(N_NEURONS) with no wrap: the terminal accept changes state instead of incrementing past the last index.

Reset
REQ-033 SHALL on reset set state to IDLE, counters to 0, and s_ready, w_we, b_we, busy, done, nan_seen to 0; w_addr, b_addr, w_data and b_data to 0.
REQ-034 SHALL, on reset asserted mid-load, suppress any pending write strobe in the following cycle and require a new start after release.

Structure
REQ-035 SHALL place the loader state enum, FP32_EXP_ONES=8'hFF and an fp32_is_nan function in shared package mlp_pkg.
REQ-036 SHALL instantiate no sub-module; the NaN check is the package function.

Verification
REQ-037 SHALL check (N_NEURONS=2, N_INPUTS=3): start, then 8 back-to-back words 1.0..8.0 -> w_addr 0..5 get 32'h3F800000..32'h40C00000, b_addr 0,1 get 7.0 and 8.0, and done rises the cycle after the last accept.
REQ-038 SHALL check that s_valid toggled 1/0 each cycle gives identical writes with gaps, and busy is held throughout.
REQ-039 SHALL check that word 3 = 32'h7FC00000 sets nan_seen, which stays set through DONE; word 32'h7F800000 alone leaves it clear.
REQ-040 SHALL check that reset after 4 weight accepts gives IDLE, s_ready=0 and no write next cycle; a new start reloads from w_addr 0.
REQ-041 SHALL check that start pulsed during LOAD_B is ignored; start in DONE restarts at w_addr 0 and clears nan_seen.
REQ-042 SHALL check that s_valid held high in IDLE and DONE causes no writes and s_ready=0.
